instr_encoder: RTL and testbench

Inverse of the ID-stage control decode. Accepts control-level instruction requests (execute command, memory/write-back/branch flags, S bit, operands) and packs each into a 32-bit instruction word in the lab ARM format. Words are streamed with a sequential byte address to the instruction-memory loader or to the testbench program builder. Illegal control combinations are dropped and counted.

---
 rtl/arm_pkg.sv | 63 ++++++
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder_pack.sv | 86 ++++++++
 rtl/instr_encoder.sv | 134 +++++++++++++
 tb/tb_instr_encoder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Field layout, opcode and execute-command constants for the lab ARM encoding.
// Also holds the request payload struct that the encoder packs into a word.
package arm_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned COND_W    = 4;
  localparam int unsigned EXE_W     = 4;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned OPERAND_W = 24;
  localparam int unsigned OFFSET_W  = 12;

  localparam int unsigned COND_LSB = 28;
  localparam int unsigned MODE_LSB = 26;
  localparam int unsigned I_BIT    = 25;
  localparam int unsigned OPC_LSB  = 21;
  localparam int unsigned S_BIT    = 20;
  localparam int unsigned RN_LSB   = 16;
  localparam int unsigned RD_LSB   = 12;
  localparam int unsigned BR_LSB   = 24;

  localparam logic [EXE_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [EXE_W-1:0] EXE_MVN = 4'b1001;
  localparam logic [EXE_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [EXE_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [EXE_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [EXE_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [EXE_W-1:0] EXE_AND = 4'b0110;
  localparam logic [EXE_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [EXE_W-1:0] EXE_EOR = 4'b1000;

  localparam logic [OPC_W-1:0] OP_MOV = 4'b1101;
  localparam logic [OPC_W-1:0] OP_MVN = 4'b1111;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADC = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SBC = 4'b0110;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ORR = 4'b1100;
  localparam logic [OPC_W-1:0] OP_EOR = 4'b0001;
  localparam logic [OPC_W-1:0] OP_CMP = 4'b1010;
  localparam logic [OPC_W-1:0] OP_TST = 4'b1000;

  localparam logic [MODE_W-1:0] MODE_DP  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_MEM = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BR  = 2'b10;

  typedef struct packed {
    logic [COND_W-1:0]    cond;
    logic [EXE_W-1:0]     exe_cmd;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_en;
    logic                 branch;
    logic                 s;
    logic                 imm;
    logic [REG_W-1:0]     rn;
    logic [REG_W-1:0]     rd;
    logic [OPERAND_W-1:0] operand;
  } req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and encoded-word stream signals between a producer, the encoder and a sink.
interface instr_encoder_if #(parameter int unsigned ADDR_WIDTH = 32);

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  req_cond;
  logic [3:0]  req_exe_cmd;
  logic        req_mem_read;
  logic        req_mem_write;
  logic        req_wb_en;
  logic        req_branch;
  logic        req_s;
  logic        req_imm;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [23:0] req_operand;

  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid, req_cond, req_exe_cmd, req_mem_read, req_mem_write,
           req_wb_en, req_branch, req_s, req_imm, req_rn, req_rd, req_operand,
           out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, req_cond, req_exe_cmd, req_mem_read, req_mem_write,
           req_wb_en, req_branch, req_s, req_imm, req_rn, req_rd, req_operand,
           out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational request-to-word mapping; flags which control combinations are legal.
module instr_pack
  import arm_pkg::*;
(
  input  req_t               req,
  output logic               legal_c,
  output logic [INSTR_W-1:0] word_c
);

  logic [3:0]        flags;
  logic              dp_ok;
  logic [OPC_W-1:0]  dp_opc;
  logic [OPC_W-1:0]  opcode;
  logic [MODE_W-1:0] mode;
  logic              ibit;
  logic              sbit;
  logic [REG_W-1:0]  rn;
  logic [REG_W-1:0]  rd;
  logic              is_branch;

  assign flags = {req.mem_read, req.mem_write, req.wb_en, req.branch};

  // Data-processing opcode lookup
  always_comb begin
    dp_ok  = 1'b1;
    dp_opc = OP_AND;
    case (req.exe_cmd)
      EXE_MOV: dp_opc = OP_MOV;
      EXE_MVN: dp_opc = OP_MVN;
      EXE_ADD: dp_opc = OP_ADD;
      EXE_ADC: dp_opc = OP_ADC;
      EXE_SUB: dp_opc = OP_SUB;
      EXE_SBC: dp_opc = OP_SBC;
      EXE_AND: dp_opc = OP_AND;
      EXE_ORR: dp_opc = OP_ORR;
      EXE_EOR: dp_opc = OP_EOR;
      default: dp_ok  = 1'b0;
    endcase
  end

  always_comb begin
    legal_c   = 1'b0;
    is_branch = 1'b0;
    opcode    = dp_opc;
    mode      = MODE_DP;
    ibit      = req.imm;
    sbit      = req.s;
    rn        = req.rn;
    rd        = req.rd;
    if (flags == 4'b0010 && dp_ok) begin
      legal_c = 1'b1;
      if (req.exe_cmd == EXE_MOV || req.exe_cmd == EXE_MVN) rn = '0;
    end else if (flags == 4'b0000 && (req.exe_cmd == EXE_SUB || req.exe_cmd == EXE_AND)) begin
      legal_c = 1'b1;
      opcode  = (req.exe_cmd == EXE_SUB) ? OP_CMP : OP_TST;
      sbit    = 1'b1;
      rd      = '0;
    end else if ((flags == 4'b1010 || flags == 4'b0100) && req.exe_cmd == EXE_ADD) begin
      // LDR sets S, STR clears it; both use an offset with I = 0
      legal_c = 1'b1;
      mode    = MODE_MEM;
      opcode  = OP_ADD;
      ibit    = 1'b0;
      sbit    = req.mem_read;
    end else if (flags == 4'b0001) begin
      legal_c   = 1'b1;
      is_branch = 1'b1;
    end

    if (is_branch) begin
      word_c = (INSTR_W'(req.cond) << COND_LSB)
             | (INSTR_W'({MODE_BR, 2'b10}) << BR_LSB)
             | INSTR_W'(req.operand);
    end else begin
      word_c = (INSTR_W'(req.cond) << COND_LSB)
             | (INSTR_W'(mode) << MODE_LSB)
             | (INSTR_W'(ibit) << I_BIT)
             | (INSTR_W'(opcode) << OPC_LSB)
             | (INSTR_W'(sbit) << S_BIT)
             | (INSTR_W'(rn) << RN_LSB)
             | (INSTR_W'(rd) << RD_LSB)
             | INSTR_W'(req.operand[OFFSET_W-1:0]);
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words with sequential byte addresses through an
// output register plus one-entry skid buffer; counts dropped illegal requests.
module instr_encoder
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic                     clear_err,
  instr_encoder_if.slave           bus,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned WORD_BYTES = 4;

  req_t               req;
  logic               legal_c;
  logic [INSTR_W-1:0] word_c;

  logic                     out_valid_q, out_valid_n;
  logic [INSTR_W-1:0]       out_instr_q, out_instr_n;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_n;
  logic                     skid_valid_q, skid_valid_n;
  logic [INSTR_W-1:0]       skid_instr_q, skid_instr_n;
  logic                     err_q, err_n;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_n;

  logic accept_c;
  logic fire_c;
  logic illegal_c;

  always_comb begin
    req.cond      = bus.req_cond;
    req.exe_cmd   = bus.req_exe_cmd;
    req.mem_read  = bus.req_mem_read;
    req.mem_write = bus.req_mem_write;
    req.wb_en     = bus.req_wb_en;
    req.branch    = bus.req_branch;
    req.s         = bus.req_s;
    req.imm       = bus.req_imm;
    req.rn        = bus.req_rn;
    req.rd        = bus.req_rd;
    req.operand   = bus.req_operand;
  end

  instr_pack u_pack (
    .req     (req),
    .legal_c (legal_c),
    .word_c  (word_c)
  );

  assign accept_c  = bus.in_valid & ~skid_valid_q & ~restart;
  assign fire_c    = out_valid_q & bus.out_ready;
  assign illegal_c = accept_c & ~legal_c;

  // Output register / skid buffer / address counter next state
  always_comb begin
    out_valid_n  = out_valid_q;
    out_instr_n  = out_instr_q;
    addr_n       = addr_q;
    skid_valid_n = skid_valid_q;
    skid_instr_n = skid_instr_q;
    if (restart) begin
      out_valid_n  = 1'b0;
      out_instr_n  = '0;
      addr_n       = '0;
      skid_valid_n = 1'b0;
      skid_instr_n = '0;
    end else begin
      if (fire_c) addr_n = addr_q + ADDR_WIDTH'(WORD_BYTES);
      if (skid_valid_q) begin
        if (fire_c) begin
          out_instr_n  = skid_instr_q;
          skid_valid_n = 1'b0;
        end
      end else if (accept_c && legal_c) begin
        if (!out_valid_q || fire_c) begin
          out_valid_n = 1'b1;
          out_instr_n = word_c;
        end else begin
          skid_valid_n = 1'b1;
          skid_instr_n = word_c;
        end
      end else if (fire_c) begin
        out_valid_n = 1'b0;
      end
    end
  end

  // Sticky flag and saturating counter; a same-cycle illegal beats clear_err
  always_comb begin
    err_n = err_q;
    cnt_n = cnt_q;
    if (clear_err) begin
      err_n = illegal_c;
      cnt_n = illegal_c ? ERR_CNT_WIDTH'(1) : '0;
    end else if (illegal_c) begin
      err_n = 1'b1;
      if (!(&cnt_q)) cnt_n = cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      addr_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_n;
      out_instr_q  <= out_instr_n;
      addr_q       <= addr_n;
      skid_valid_q <= skid_valid_n;
      skid_instr_q <= skid_instr_n;
      err_q        <= err_n;
      cnt_q        <= cnt_n;
    end
  end

  assign bus.in_ready  = ~skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = addr_q;
  assign err           = err_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written corner sequences,
// and randomized traffic scored against an encoding model.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       clear_err;
  logic       err;
  logic [7:0] err_count;

  instr_encoder_if #(.ADDR_WIDTH(32)) bus ();

  instr_encoder #(.ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .clear_err (clear_err),
    .bus       (bus),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cond;
    logic [3:0]  exe;
    logic [3:0]  flags;   // {mem_read, mem_write, wb_en, branch}
    logic        s;
    logic        imm;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] op;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];
  logic [31:0] sb[$];

  // Opcode per exe_cmd for data-processing requests, -1 where undefined
  int dp_op [16] = '{-1, 13, 4, 5, 2, 6, 0, 12, 1, 15, -1, -1, -1, -1, -1, -1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] cond, input logic [3:0] exe,
                              input logic [3:0] flags, input logic s, input logic imm,
                              input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] op,
                              input logic legal, input logic [31:0] word);
    vec_t v;
    v.name = nm; v.cond = cond; v.exe = exe; v.flags = flags; v.s = s; v.imm = imm;
    v.rn = rn; v.rd = rd; v.op = op; v.legal = legal; v.word = word;
    return v;
  endfunction

  // Encoding model: classify by flag pattern, then assemble fields arithmetically
  function automatic logic [32:0] model(input vec_t v);
    int unsigned mode, opc, s, i, rn, rd;
    bit ok;
    ok = 0; mode = 0; opc = 0; s = v.s; i = v.imm; rn = v.rn; rd = v.rd;
    if (v.flags == 4'b0010 && dp_op[v.exe] >= 0) begin
      ok = 1; opc = dp_op[v.exe];
      if (v.exe == 1 || v.exe == 9) rn = 0;
    end else if (v.flags == 4'b0000 && (v.exe == 4 || v.exe == 6)) begin
      ok = 1; opc = (v.exe == 4) ? 10 : 8; s = 1; rd = 0;
    end else if (v.flags == 4'b1010 && v.exe == 2) begin
      ok = 1; mode = 1; i = 0; opc = 4; s = 1;
    end else if (v.flags == 4'b0100 && v.exe == 2) begin
      ok = 1; mode = 1; i = 0; opc = 4; s = 0;
    end else if (v.flags == 4'b0001) begin
      return {1'b1, 32'(v.cond) * 32'h1000_0000 + 32'h0A00_0000 + 32'(v.op)};
    end
    return {ok, 32'(v.cond) * 32'h1000_0000 + 32'(mode) * 32'h0400_0000 + 32'(i) * 32'h0200_0000
              + 32'(opc) * 32'h0020_0000 + 32'(s) * 32'h0010_0000 + 32'(rn) * 32'h1_0000
              + 32'(rd) * 32'h1000 + 32'(v.op % 4096)};
  endfunction

  task automatic set_req(input vec_t v);
    bus.req_cond      = v.cond;
    bus.req_exe_cmd   = v.exe;
    bus.req_mem_read  = v.flags[3];
    bus.req_mem_write = v.flags[2];
    bus.req_wb_en     = v.flags[1];
    bus.req_branch    = v.flags[0];
    bus.req_s         = v.s;
    bus.req_imm       = v.imm;
    bus.req_rn        = v.rn;
    bus.req_rd        = v.rd;
    bus.req_operand   = v.op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; clear_err = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int cls;
    v = mk("rnd", 4'($urandom), 4'($urandom_range(0, 9)), 4'b0010, 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), 24'($urandom), 1'b0, 32'h0);
    cls = $urandom_range(0, 6);
    case (cls)
      1: begin v.flags = 4'b0000; v.exe = ($urandom_range(0, 1) != 0) ? 4'd4 : 4'd6; end
      2: begin v.flags = 4'b1010; v.exe = 4'd2; end
      3: begin v.flags = 4'b0100; v.exe = 4'd2; end
      4: v.flags = 4'b0001;
      5: begin v.flags = 4'($urandom); v.exe = 4'($urandom); end
      default: ;
    endcase
    return v;
  endfunction

  initial begin : main
    logic [31:0] exp_addr;
    int          n_ill;
    logic [32:0] m;
    vec_t        v, va, vb, vc;
    logic        prev_stall;
    logic [31:0] prev_instr, prev_addr;

    bus.req_cond = '0; bus.req_exe_cmd = '0; bus.req_mem_read = 0; bus.req_mem_write = 0;
    bus.req_wb_en = 0; bus.req_branch = 0; bus.req_s = 0; bus.req_imm = 0;
    bus.req_rn = '0; bus.req_rd = '0; bus.req_operand = '0;

    vecs.push_back(mk("add",  4'hE, 4'h2, 4'b0010, 0, 1, 4'h2, 4'h1, 24'h000005, 1, 32'hE2821005));
    vecs.push_back(mk("cmp",  4'hE, 4'h4, 4'b0000, 0, 0, 4'h3, 4'h7, 24'h000004, 1, 32'hE1530004));
    vecs.push_back(mk("ldr",  4'hE, 4'h2, 4'b1010, 0, 1, 4'h1, 4'h0, 24'h000008, 1, 32'hE4910008));
    vecs.push_back(mk("b",    4'hE, 4'h5, 4'b0001, 1, 0, 4'h0, 4'h0, 24'hFFFFFE, 1, 32'hEAFFFFFE));
    vecs.push_back(mk("rdwr", 4'hE, 4'h2, 4'b1100, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));
    vecs.push_back(mk("str",  4'hE, 4'h2, 4'b0100, 1, 1, 4'h4, 4'h5, 24'h000010, 1, 32'hE4845010));
    vecs.push_back(mk("mov",  4'h0, 4'h1, 4'b0010, 1, 1, 4'h9, 4'h3, 24'h123456, 1, 32'h03B03456));
    vecs.push_back(mk("mvn",  4'h1, 4'h9, 4'b0010, 0, 0, 4'h5, 4'h2, 24'h00000F, 1, 32'h11E0200F));
    vecs.push_back(mk("dp0",  4'hE, 4'h0, 4'b0010, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));
    vecs.push_back(mk("tst",  4'h2, 4'h6, 4'b0000, 0, 1, 4'h6, 4'h9, 24'h0000FF, 1, 32'h231600FF));
    vecs.push_back(mk("sbc",  4'h3, 4'h5, 4'b0010, 1, 0, 4'h7, 4'h8, 24'h000FFF, 1, 32'h30D78FFF));
    vecs.push_back(mk("cmpad",4'hE, 4'h2, 4'b0000, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));
    vecs.push_back(mk("eor",  4'h4, 4'h8, 4'b0010, 0, 1, 4'hA, 4'hB, 24'h000001, 1, 32'h422AB001));
    vecs.push_back(mk("and",  4'h5, 4'h6, 4'b0010, 0, 0, 4'h1, 4'h2, 24'h000002, 1, 32'h50012002));
    vecs.push_back(mk("bwb",  4'hE, 4'h0, 4'b0011, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));
    vecs.push_back(mk("orr",  4'h6, 4'h7, 4'b0010, 1, 0, 4'h3, 4'h4, 24'h000003, 1, 32'h61934003));
    vecs.push_back(mk("ldrsb",4'hE, 4'h4, 4'b1010, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));
    vecs.push_back(mk("adc",  4'h7, 4'h3, 4'b0010, 1, 1, 4'h5, 4'h6, 24'h000004, 1, 32'h72B56004));
    vecs.push_back(mk("dpA",  4'hE, 4'hA, 4'b0010, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));
    vecs.push_back(mk("sub",  4'h8, 4'h4, 4'b0010, 0, 0, 4'h7, 4'h8, 24'h000005, 1, 32'h80478005));
    vecs.push_back(mk("strwb",4'hE, 4'h2, 4'b0110, 0, 0, 4'h1, 4'h1, 24'h000001, 0, 32'h0));

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_err", 32'(err), 0);
    check("rst_err_count", 32'(err_count), 0);

    // Directed table, one request per cycle with a free sink
    exp_addr = 0; n_ill = 0;
    foreach (vecs[i]) begin
      set_req(vecs[i]);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'(vecs[i].legal));
      if (vecs[i].legal) begin
        check({vecs[i].name, "_instr"}, bus.out_instr, vecs[i].word);
        check({vecs[i].name, "_addr"}, bus.out_addr, exp_addr);
        exp_addr += 4;
      end else begin
        n_ill++;
        check({vecs[i].name, "_err"}, 32'(err), 1);
      end
      check({vecs[i].name, "_errcnt"}, 32'(err_count), 32'(n_ill));
    end
    step();
    check("tbl_drained", 32'(bus.out_valid), 0);

    // Backpressure: three legal words against a stalled sink
    do_reset();
    va = vecs[0]; vb = vecs[1]; vc = vecs[2];
    bus.out_ready = 1'b0;
    set_req(va); bus.in_valid = 1'b1; step();
    check("bp_a_instr", bus.out_instr, va.word);
    check("bp_ready_after_1", 32'(bus.in_ready), 1);
    set_req(vb); step();
    check("bp_ready_after_2", 32'(bus.in_ready), 0);
    check("bp_hold1_instr", bus.out_instr, va.word);
    set_req(vc); step();
    check("bp_hold2_instr", bus.out_instr, va.word);
    check("bp_hold2_addr", bus.out_addr, 0);
    check("bp_hold2_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1; step();
    check("bp_b_instr", bus.out_instr, vb.word);
    check("bp_b_addr", bus.out_addr, 4);
    check("bp_b_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_c_instr", bus.out_instr, vc.word);
    check("bp_c_addr", bus.out_addr, 8);
    check("bp_c_valid", 32'(bus.out_valid), 1);
    step();
    check("bp_empty", 32'(bus.out_valid), 0);

    // Illegal handling: clear in the same cycle, then saturation, then clear
    do_reset();
    set_req(vecs[4]); bus.in_valid = 1'b1; clear_err = 1'b1; step();
    clear_err = 1'b0;
    check("clr_same_err", 32'(err), 1);
    check("clr_same_cnt", 32'(err_count), 1);
    for (int k = 0; k < 300; k++) step();
    bus.in_valid = 1'b0;
    check("sat_cnt", 32'(err_count), 255);
    check("sat_err", 32'(err), 1);
    check("sat_no_out", 32'(bus.out_valid), 0);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("clr_err", 32'(err), 0);
    check("clr_cnt", 32'(err_count), 0);

    // Restart with a full pipeline; error state survives
    do_reset();
    set_req(vecs[8]); bus.in_valid = 1'b1; step();
    bus.out_ready = 1'b0;
    set_req(va); step();
    set_req(vb); step();
    check("rs_full_ready", 32'(bus.in_ready), 0);
    restart = 1'b1; set_req(vc); step();
    restart = 1'b0; bus.in_valid = 1'b0;
    check("rs_valid", 32'(bus.out_valid), 0);
    check("rs_instr", bus.out_instr, 0);
    check("rs_addr", bus.out_addr, 0);
    check("rs_ready", 32'(bus.in_ready), 1);
    check("rs_err", 32'(err), 1);
    check("rs_cnt", 32'(err_count), 1);
    bus.out_ready = 1'b1; set_req(vc); bus.in_valid = 1'b1; step();
    bus.in_valid = 1'b0;
    check("rs_next_instr", bus.out_instr, vc.word);
    check("rs_next_addr", bus.out_addr, 0);
    restart = 1'b1; set_req(va); bus.in_valid = 1'b1; step();
    restart = 1'b0; bus.in_valid = 1'b0;
    check("rs_drop_valid", 32'(bus.out_valid), 0);
    set_req(vecs[4]); bus.in_valid = 1'b1; restart = 1'b1; step();
    restart = 1'b0; bus.in_valid = 1'b0;
    check("rs_drop_cnt", 32'(err_count), 1);
    step();
    check("rs_drop_valid2", 32'(bus.out_valid), 0);

    // Randomized traffic against the model with random backpressure
    do_reset();
    exp_addr = 0; n_ill = 0; prev_stall = 0; prev_instr = 0; prev_addr = 0;
    sb.delete();
    for (int c = 0; c < 1500; c++) begin
      if (c < 1450) begin
        v = rand_vec();
        set_req(v);
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (prev_stall) begin
        check("rnd_stable_instr", bus.out_instr, prev_instr);
        check("rnd_stable_addr", bus.out_addr, prev_addr);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("rnd_sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check("rnd_instr", bus.out_instr, sb.pop_front());
          check("rnd_addr", bus.out_addr, exp_addr);
        end
        exp_addr += 4;
      end
      if (bus.in_valid && bus.in_ready) begin
        m = model(v);
        if (m[32]) sb.push_back(m[31:0]);
        else n_ill++;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_instr = bus.out_instr;
      prev_addr  = bus.out_addr;
      @(posedge clk); #1;
    end
    check("rnd_drained", 32'(sb.size()), 0);
    check("rnd_out_idle", 32'(bus.out_valid), 0);
    check("rnd_err", 32'(err), 32'(n_ill > 0));
    check("rnd_err_count", 32'(err_count), 32'((n_ill > 255) ? 255 : n_ill));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
